// File: rtl/integration_scheduler_if.sv
// ----------------------------------------------------------------------------
// integration_scheduler_if
//
// Purpose:
//   Bundles the configuration, half-spectrum input stream, frame output
//   handshake and status signals of integration_scheduler into one port.
//
// Parameters:
//   SUM_WIDTH  width of one half-spectrum channel sum
//   ACC_WIDTH  width of the frame accumulator / acc_out
//   CNT_WIDTH  width of integration length and counters
//
// Signals (direction as seen from the scheduler, i.e. the slave modport):
//   cfg_int_len    in   spectra per frame, sampled on an accepted cfg_start
//   cfg_start      in   arm pulse
//   cfg_stop       in   stop pulse
//   sum_in         in   half-spectrum sum, unsigned
//   sum_in_valid   in   sum_in qualifier, no backpressure
//   sum_in_half    in   0 = lower channel half, 1 = upper channel half
//   acc_out        out  integrated frame
//   acc_out_valid  out  frame valid, held until acc_out_ready
//   acc_out_ready  in   downstream accept
//   acc_ovf        out  frame accumulator overflow, qualified by acc_out_valid
//   seq_err        out  sticky half-order violation flag
//   drop_cnt       out  saturating count of beats dropped while stalled
//   busy           out  high whenever the scheduler is not idle
//
// Modports:
//   master  the upstream/downstream environment that drives the scheduler
//   slave   the scheduler itself
// ----------------------------------------------------------------------------
interface integration_scheduler_if #(
  parameter int SUM_WIDTH = 22,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] cfg_int_len;
  logic                 cfg_start;
  logic                 cfg_stop;
  logic [SUM_WIDTH-1:0] sum_in;
  logic                 sum_in_valid;
  logic                 sum_in_half;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 acc_out_valid;
  logic                 acc_out_ready;
  logic                 acc_ovf;
  logic                 seq_err;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic                 busy;

  modport master (
    output cfg_int_len, cfg_start, cfg_stop,
    output sum_in, sum_in_valid, sum_in_half,
    output acc_out_ready,
    input  acc_out, acc_out_valid, acc_ovf,
    input  seq_err, drop_cnt, busy
  );

  modport slave (
    input  cfg_int_len, cfg_start, cfg_stop,
    input  sum_in, sum_in_valid, sum_in_half,
    input  acc_out_ready,
    output acc_out, acc_out_valid, acc_ovf,
    output seq_err, drop_cnt, busy
  );
endinterface

// File: rtl/integration_scheduler.sv
// ----------------------------------------------------------------------------
// integration_scheduler
//
// Purpose:
//   Turns the channel adder's half-spectrum sums (two beats per spectrum,
//   lower half then upper half) into time-integrated frames for the FRB
//   trigger path. Pairs the halves into a spectrum, accumulates cfg_int_len
//   spectra per frame and presents each frame on a valid/ready handshake,
//   all under a start/stop control FSM (IDLE, WAIT_H0, WAIT_H1, OUT).
//
// Ports:
//   clk_data   in   data clock, single clock domain
//   rst_n      in   synchronous reset, active-low
//   bus        integration_scheduler_if.slave: configuration, sum_in stream,
//              acc_out handshake and status (see the interface header)
//
// Configuration macro:
//   INTEG_SCHED_SATURATE_EN
//     defined   : accumulator clamps at 2^ACC_WIDTH-1, acc_ovf set for the frame
//     undefined : accumulator wraps modulo 2^ACC_WIDTH, acc_ovf set if any
//                 carry-out occurred during the frame (default build)
// ----------------------------------------------------------------------------
module integration_scheduler #(
  parameter int SUM_WIDTH = 22,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk_data,
  input  logic                    rst_n,
  integration_scheduler_if.slave  bus
);

  // Adder width wide enough for both the accumulator and one full spectrum,
  // plus one bit so the carry-out is never lost even when ACC_WIDTH is small.
  localparam int SPEC_W = SUM_WIDTH + 1;
  localparam int EXT_W  = ((ACC_WIDTH > SPEC_W) ? ACC_WIDTH : SPEC_W) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_H0 = 2'd1,
    WAIT_H1 = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] len_reg;
  logic [CNT_WIDTH-1:0] spec_cnt_reg;
  logic [SUM_WIDTH-1:0] h0_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic                 ovf_reg;
  logic                 stop_pend_reg;
  logic [ACC_WIDTH-1:0] acc_out_reg;
  logic                 acc_out_valid_reg;
  logic                 seq_err_reg;
  logic [CNT_WIDTH-1:0] drop_cnt_reg;
  logic                 busy_reg;

  logic [SPEC_W-1:0]    spec_next;
  logic [EXT_W-1:0]     sum_ext_next;
  logic                 carry_next;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;
  logic                 last_spec_next;
  logic                 handshake_next;

  // Spectrum sum and accumulator update for a half-1 beat in WAIT_H1.
  always_comb begin
    spec_next    = {1'b0, h0_reg} + {1'b0, bus.sum_in};
    sum_ext_next = EXT_W'(acc_reg) + EXT_W'(spec_next);
    carry_next   = |sum_ext_next[EXT_W-1:ACC_WIDTH];
`ifdef INTEG_SCHED_SATURATE_EN
    acc_next     = carry_next ? {ACC_WIDTH{1'b1}} : sum_ext_next[ACC_WIDTH-1:0];
`else
    acc_next     = sum_ext_next[ACC_WIDTH-1:0];
`endif
    ovf_next       = ovf_reg | carry_next;
    last_spec_next = (spec_cnt_reg == (len_reg - CNT_WIDTH'(1)));
    handshake_next = acc_out_valid_reg & bus.acc_out_ready;
  end

  always_ff @(posedge clk_data) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      len_reg           <= '0;
      spec_cnt_reg      <= '0;
      h0_reg            <= '0;
      acc_reg           <= '0;
      ovf_reg           <= 1'b0;
      stop_pend_reg     <= 1'b0;
      acc_out_reg       <= '0;
      acc_out_valid_reg <= 1'b0;
      seq_err_reg       <= 1'b0;
      drop_cnt_reg      <= '0;
      busy_reg          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A start takes priority over a simultaneous stop; any beat in
          // this cycle is ignored so the first accepted beat comes next cycle.
          if (bus.cfg_start) begin
            len_reg       <= (bus.cfg_int_len == '0) ? CNT_WIDTH'(1) : bus.cfg_int_len;
            acc_reg       <= '0;
            spec_cnt_reg  <= '0;
            ovf_reg       <= 1'b0;
            stop_pend_reg <= 1'b0;
            seq_err_reg   <= 1'b0;
            drop_cnt_reg  <= '0;
            state_reg     <= WAIT_H0;
            busy_reg      <= 1'b1;
          end
        end

        WAIT_H0: begin
          if (bus.cfg_stop) begin
            // Partial frame is abandoned without output.
            acc_reg      <= '0;
            spec_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
          end else if (bus.sum_in_valid) begin
            if (!bus.sum_in_half) begin
              h0_reg    <= bus.sum_in;
              state_reg <= WAIT_H1;
            end else begin
              // Upper half without a lower half: drop it and flag.
              seq_err_reg <= 1'b1;
            end
          end
        end

        WAIT_H1: begin
          if (bus.cfg_stop) begin
            acc_reg      <= '0;
            spec_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
          end else if (bus.sum_in_valid) begin
            if (bus.sum_in_half) begin
              acc_reg <= acc_next;
              ovf_reg <= ovf_next;
              if (last_spec_next) begin
                // Frame result is captured here so acc_out stays frozen
                // for the whole OUT stall, whatever arrives on sum_in.
                acc_out_reg       <= acc_next;
                acc_out_valid_reg <= 1'b1;
                state_reg         <= OUT;
              end else begin
                spec_cnt_reg <= spec_cnt_reg + CNT_WIDTH'(1);
                state_reg    <= WAIT_H0;
              end
            end else begin
              // Second lower half in a row: the newest one wins.
              h0_reg      <= bus.sum_in;
              seq_err_reg <= 1'b1;
            end
          end
        end

        OUT: begin
          // Nothing is accepted here, including the handshake cycle.
          if (bus.sum_in_valid && (drop_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
          end
          if (handshake_next) begin
            acc_reg           <= '0;
            spec_cnt_reg      <= '0;
            ovf_reg           <= 1'b0;
            acc_out_valid_reg <= 1'b0;
            stop_pend_reg     <= 1'b0;
            if (stop_pend_reg || bus.cfg_stop) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= WAIT_H0;
            end
          end else if (bus.cfg_stop) begin
            stop_pend_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_out       = acc_out_reg;
  assign bus.acc_out_valid = acc_out_valid_reg;
  assign bus.acc_ovf       = ovf_reg;
  assign bus.seq_err       = seq_err_reg;
  assign bus.drop_cnt      = drop_cnt_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_integration_scheduler.sv
// ----------------------------------------------------------------------------
// tb_integration_scheduler
//
// Self-checking bench for integration_scheduler. A main 40-bit instance runs
// a table of frame vectors plus hand-written multi-cycle sequences; a second
// instance with a 22-bit accumulator exercises accumulator overflow. Frames
// seen on the main instance are checked against a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_integration_scheduler;

  localparam int SW  = 22;
  localparam int AW  = 40;
  localparam int AW2 = 22;
  localparam int CW  = 16;

  logic clk_data = 1'b0;
  logic rst_n    = 1'b0;

  always #5 clk_data = ~clk_data;

  integration_scheduler_if #(.SUM_WIDTH(SW), .ACC_WIDTH(AW),  .CNT_WIDTH(CW)) bus  ();
  integration_scheduler_if #(.SUM_WIDTH(SW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) bus2 ();

  integration_scheduler #(.SUM_WIDTH(SW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  integration_scheduler #(.SUM_WIDTH(SW), .ACC_WIDTH(AW2), .CNT_WIDTH(CW)) dut_narrow (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .bus      (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [CW-1:0] len;
    logic [SW-1:0] lo;
    logic [SW-1:0] hi;
    int            stall;
    logic [AW-1:0] exp_acc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_data);
    #1;
  endtask

  task automatic beat(input logic half, input logic [SW-1:0] val);
    bus.sum_in       = val;
    bus.sum_in_half  = half;
    bus.sum_in_valid = 1'b1;
    tick();
    bus.sum_in_valid = 1'b0;
  endtask

  task automatic spectrum(input logic [SW-1:0] lo, input logic [SW-1:0] hi);
    beat(1'b0, lo);
    beat(1'b1, hi);
  endtask

  task automatic start(input logic [CW-1:0] len);
    bus.cfg_int_len = len;
    bus.cfg_start   = 1'b1;
    tick();
    bus.cfg_start   = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] acc, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Accept the pending frame and return to IDLE in the same cycle.
  task automatic accept_and_stop();
    bus.acc_out_ready = 1'b1;
    bus.cfg_stop      = 1'b1;
    tick();
    bus.acc_out_ready = 1'b0;
    bus.cfg_stop      = 1'b0;
  endtask

  // Scoreboard: each handshake on the main instance pops one expected frame.
  always @(negedge clk_data) begin
    if (rst_n && bus.acc_out_valid && bus.acc_out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard: unexpected frame acc=%0d, required none", bus.acc_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_acc", 64'(bus.acc_out), 64'(e.acc));
        check("frame_ovf", 64'(bus.acc_ovf), 64'(e.ovf));
        $display("frame: acc=%0d ovf=%0b (expected acc=%0d ovf=%0b)",
                 bus.acc_out, bus.acc_ovf, e.acc, e.ovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nspec;
    logic [AW2-1:0] ovf_exp;

    vecs[0] = '{16'd4, 22'd100,      22'd200,      5, 40'd1200};
    vecs[1] = '{16'd0, 22'd7,        22'd8,        0, 40'd15};
    vecs[2] = '{16'd1, 22'h3FFFFF,   22'h3FFFFF,   2, 40'h7FFFFE};
    vecs[3] = '{16'd3, 22'd1000,     22'd24,       1, 40'd3072};
    vecs[4] = '{16'd2, 22'h200000,   22'h1FFFFF,   3, 40'h7FFFFE};

    bus.cfg_int_len    = '0;
    bus.cfg_start      = 1'b0;
    bus.cfg_stop       = 1'b0;
    bus.sum_in         = '0;
    bus.sum_in_valid   = 1'b0;
    bus.sum_in_half    = 1'b0;
    bus.acc_out_ready  = 1'b0;
    bus2.cfg_int_len   = '0;
    bus2.cfg_start     = 1'b0;
    bus2.cfg_stop      = 1'b0;
    bus2.sum_in        = '0;
    bus2.sum_in_valid  = 1'b0;
    bus2.sum_in_half   = 1'b0;
    bus2.acc_out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    check("rst_valid",    64'(bus.acc_out_valid), 64'd0);
    check("rst_busy",     64'(bus.busy),          64'd0);
    check("rst_acc_out",  64'(bus.acc_out),       64'd0);
    check("rst_seq_err",  64'(bus.seq_err),       64'd0);
    check("rst_drop_cnt", 64'(bus.drop_cnt),      64'd0);
    check("rst_acc_ovf",  64'(bus.acc_ovf),       64'd0);

    // Beats while IDLE are ignored entirely
    beat(1'b1, 22'd5);
    check("idle_busy", 64'(bus.busy), 64'd0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      nspec = (vecs[i].len == 0) ? 1 : int'(vecs[i].len);
      start(vecs[i].len);
      check($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
      for (int s = 0; s < nspec; s++) begin
        if (s == nspec - 1) begin
          push_exp(vecs[i].exp_acc, 1'b0);
          beat(1'b0, vecs[i].lo);
          check($sformatf("v%0d_valid_early", i), 64'(bus.acc_out_valid), 64'd0);
          beat(1'b1, vecs[i].hi);
        end else begin
          spectrum(vecs[i].lo, vecs[i].hi);
        end
      end
      check($sformatf("v%0d_latency", i), 64'(bus.acc_out_valid), 64'd1);
      for (int k = 0; k < vecs[i].stall; k++) begin
        tick();
        check($sformatf("v%0d_hold_valid", i), 64'(bus.acc_out_valid), 64'd1);
        check($sformatf("v%0d_hold_acc", i),   64'(bus.acc_out),       64'(vecs[i].exp_acc));
      end
      accept_and_stop();
      check($sformatf("v%0d_post_valid", i), 64'(bus.acc_out_valid), 64'd0);
      check($sformatf("v%0d_post_busy", i),  64'(bus.busy),          64'd0);
      $display("vector %0d: len=%0d lo=%0d hi=%0d done", i, vecs[i].len, vecs[i].lo, vecs[i].hi);
    end

    // Order error: h0=10, h0=20, h1=5, h0=1, h1=1 -> 25 + 2
    start(16'd2);
    beat(1'b0, 22'd10);
    beat(1'b0, 22'd20);
    check("order_seq_err", 64'(bus.seq_err), 64'd1);
    beat(1'b1, 22'd5);
    push_exp(40'd27, 1'b0);
    spectrum(22'd1, 22'd1);
    check("order_valid", 64'(bus.acc_out_valid), 64'd1);
    accept_and_stop();
    check("order_seq_err_sticky", 64'(bus.seq_err), 64'd1);
    start(16'd1);
    check("order_seq_err_clear", 64'(bus.seq_err), 64'd0);
    $display("order error sequence done");

    // Upper half first in WAIT_H0 is discarded and flagged
    beat(1'b1, 22'd77);
    check("h1_first_seq_err", 64'(bus.seq_err), 64'd1);

    // Stall drops (len=1 already armed)
    push_exp(40'd11, 1'b0);
    spectrum(22'd5, 22'd6);
    for (int k = 0; k < 6; k++) begin
      beat(1'(k % 2), 22'd999);
      check("stall_drop_cnt", 64'(bus.drop_cnt), 64'(k + 1));
      check("stall_acc_out",  64'(bus.acc_out),  64'd11);
    end
    bus.acc_out_ready = 1'b1;
    tick();
    bus.acc_out_ready = 1'b0;
    check("stall_back_busy",  64'(bus.busy),          64'd1);
    check("stall_back_valid", 64'(bus.acc_out_valid), 64'd0);
    push_exp(40'd7, 1'b0);
    spectrum(22'd3, 22'd4);
    check("stall_next_valid", 64'(bus.acc_out_valid), 64'd1);
    accept_and_stop();
    check("stall_drop_kept", 64'(bus.drop_cnt), 64'd6);
    start(16'd1);
    check("stall_drop_clear", 64'(bus.drop_cnt), 64'd0);
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    $display("stall sequence done");

    // Stop in WAIT_H1 after 2 of 8 spectra: no output
    start(16'd8);
    spectrum(22'd1, 22'd1);
    spectrum(22'd1, 22'd1);
    beat(1'b0, 22'd1);
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    check("stop_h1_busy", 64'(bus.busy), 64'd0);
    tick(); tick(); tick();
    check("stop_h1_valid", 64'(bus.acc_out_valid), 64'd0);

    // Stop during OUT: leave only after the handshake
    start(16'd1);
    push_exp(40'd3, 1'b0);
    spectrum(22'd1, 22'd2);
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    check("stop_out_busy",  64'(bus.busy),          64'd1);
    check("stop_out_valid", 64'(bus.acc_out_valid), 64'd1);
    tick();
    check("stop_out_hold", 64'(bus.acc_out_valid), 64'd1);
    bus.acc_out_ready = 1'b1;
    tick();
    bus.acc_out_ready = 1'b0;
    check("stop_out_idle", 64'(bus.busy), 64'd0);
    $display("stop sequences done");

    // Start with a simultaneous beat; a later start is ignored
    bus.cfg_int_len  = 16'd2;
    bus.cfg_start    = 1'b1;
    bus.sum_in       = 22'd50;
    bus.sum_in_half  = 1'b0;
    bus.sum_in_valid = 1'b1;
    tick();
    bus.cfg_start    = 1'b0;
    bus.sum_in_valid = 1'b0;
    start(16'd1);
    spectrum(22'd1, 22'd2);
    check("restart_ignored", 64'(bus.acc_out_valid), 64'd0);
    push_exp(40'd10, 1'b0);
    spectrum(22'd3, 22'd4);
    check("start_beat_valid",   64'(bus.acc_out_valid), 64'd1);
    check("start_beat_seq_err", 64'(bus.seq_err),       64'd0);
    accept_and_stop();
    $display("start corner sequence done");

    // Overflow on the 22-bit accumulator instance
`ifdef INTEG_SCHED_SATURATE_EN
    ovf_exp = 22'h3FFFFF;
`else
    ovf_exp = 22'h3FFFFE;
`endif
    bus2.cfg_int_len = 16'd1;
    bus2.cfg_start   = 1'b1;
    tick();
    bus2.cfg_start    = 1'b0;
    bus2.sum_in       = 22'h3FFFFF;
    bus2.sum_in_half  = 1'b0;
    bus2.sum_in_valid = 1'b1;
    tick();
    bus2.sum_in_half  = 1'b1;
    tick();
    bus2.sum_in_valid = 1'b0;
    check("ovf_valid", 64'(bus2.acc_out_valid), 64'd1);
    check("ovf_acc",   64'(bus2.acc_out),       64'(ovf_exp));
    check("ovf_flag",  64'(bus2.acc_ovf),       64'd1);
    bus2.acc_out_ready = 1'b1;
    bus2.cfg_stop      = 1'b1;
    tick();
    bus2.acc_out_ready = 1'b0;
    bus2.cfg_stop      = 1'b0;
    check("ovf_flag_clear", 64'(bus2.acc_ovf), 64'd0);
    $display("overflow frame: acc=0x%0h", ovf_exp);

    // Reset during WAIT_H1, then a normal frame
    start(16'd4);
    spectrum(22'd100, 22'd200);
    beat(1'b0, 22'd100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_valid",   64'(bus.acc_out_valid), 64'd0);
    check("mrst_busy",    64'(bus.busy),          64'd0);
    check("mrst_acc_out", 64'(bus.acc_out),       64'd0);
    check("mrst_seq_err", 64'(bus.seq_err),       64'd0);
    check("mrst_acc_ovf", 64'(bus.acc_ovf),       64'd0);
    start(16'd4);
    bus.acc_out_ready = 1'b1;
    push_exp(40'd1200, 1'b0);
    for (int s = 0; s < 4; s++) spectrum(22'd100, 22'd200);
    check("mrst_frame_valid", 64'(bus.acc_out_valid), 64'd1);
    tick();
    bus.acc_out_ready = 1'b0;
    check("mrst_back_h0", 64'(bus.busy), 64'd1);
    bus.cfg_stop = 1'b1;
    tick();
    bus.cfg_stop = 1'b0;
    $display("mid-frame reset sequence done");

    tick(); tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
